// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with a busy-bit scoreboard.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   ZERO_REG                : index of the hardwired-zero register
//   bypass_sel()            : condition under which a read returns the same-cycle write data
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ZERO_REG   = 0;

    // A read port takes the incoming write data when a write is active to the
    // same, non-zero register in the same cycle.
    function automatic logic bypass_sel(
        input logic i_regwr,
        input logic i_addr_eq,
        input logic i_rs_nonzero
    );
        return i_regwr & i_addr_eq & i_rs_nonzero;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one busy bit per register, set by allocate, cleared by
// write, allocate winning on a same-register collision. Register 0 never busy.
// Ports:
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_alloc_en, i_alloc_addr  : mark a register busy at the edge
//   i_clr_en, i_clr_addr      : clear a register's busy bit at the edge (write)
//   i_rs1, i_rs2              : read addresses
//   o_busy1_nxt_c/o_busy2_nxt_c : post-edge busy state of i_rs1/i_rs2 (combinational)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_alloc_en,
    input  logic [ADDR_W-1:0] i_alloc_addr,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    output logic              o_busy1_nxt_c,
    output logic              o_busy2_nxt_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    // Next busy vector: allocate has priority over a same-register clear.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (i_alloc_en && (i_alloc_addr == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end else if (i_clr_en && (i_clr_addr == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
        end
        w_busy_nxt[ZERO_REG] = 1'b0;
    end

    // Busy vector state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy1_nxt_c = w_busy_nxt[i_rs1];
    assign o_busy2_nxt_c = w_busy_nxt[i_rs2];

endmodule

// File: rtl/regfile_sb.sv
// Register file with two registered read ports, one write port, write-to-read
// bypass and an integrated busy-bit scoreboard for hazard detection.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   RS1, RS2, RdEn      : read addresses and read enable (outputs hold when RdEn=0)
//   RD, WData, RegWr    : write port
//   AllocEn, AllocAddr  : mark a register busy for an in-flight producer
//   RD1, RD2            : registered read data
//   Busy1, Busy2        : registered post-edge busy status of RS1/RS2
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RS1,
    input  logic [ADDR_W-1:0] RS2,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] WData,
    input  logic              RegWr,
    input  logic              AllocEn,
    input  logic [ADDR_W-1:0] AllocAddr,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              Busy1,
    output logic              Busy2
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_wr_valid;
    logic              w_rs1_nz;
    logic              w_rs2_nz;
    logic [DATA_W-1:0] w_rd1_nxt;
    logic [DATA_W-1:0] w_rd2_nxt;
    logic              w_busy1_nxt;
    logic              w_busy2_nxt;

    assign w_wr_valid = RegWr && (RD != ADDR_W'(ZERO_REG));
    assign w_rs1_nz   = (RS1 != ADDR_W'(ZERO_REG));
    assign w_rs2_nz   = (RS2 != ADDR_W'(ZERO_REG));

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .i_clk         (Clk),
        .i_reset       (Reset),
        .i_alloc_en    (AllocEn),
        .i_alloc_addr  (AllocAddr),
        .i_clr_en      (w_wr_valid),
        .i_clr_addr    (RD),
        .i_rs1         (RS1),
        .i_rs2         (RS2),
        .o_busy1_nxt_c (w_busy1_nxt),
        .o_busy2_nxt_c (w_busy2_nxt)
    );

    // Read data selection: bypass from the same-cycle write, zero for register 0.
    always_comb begin
        w_rd1_nxt = '0;
        w_rd2_nxt = '0;
        if (bypass_sel(RegWr, RD == RS1, w_rs1_nz)) begin
            w_rd1_nxt = WData;
        end else if (w_rs1_nz) begin
            w_rd1_nxt = r_regs[RS1];
        end
        if (bypass_sel(RegWr, RD == RS2, w_rs2_nz)) begin
            w_rd2_nxt = WData;
        end else if (w_rs2_nz) begin
            w_rd2_nxt = r_regs[RS2];
        end
    end

    // Data array; register 0 is never written so it stays at its reset value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[RD] <= WData;
        end
    end

    // Registered read ports; hold while RdEn is low.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RD1   <= '0;
            RD2   <= '0;
            Busy1 <= 1'b0;
            Busy2 <= 1'b0;
        end else if (RdEn) begin
            RD1   <= w_rd1_nxt;
            RD2   <= w_rd2_nxt;
            Busy1 <= w_busy1_nxt;
            Busy2 <= w_busy2_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_regfile_sb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [ADDR_W-1:0] RS1, RS2, RD, AllocAddr;
    logic              RdEn, RegWr, AllocEn;
    logic [DATA_W-1:0] WData;
    logic [DATA_W-1:0] RD1, RD2;
    logic              Busy1, Busy2;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference model state
    logic [DATA_W-1:0] m_regs [DEPTH];
    logic              m_busy [DEPTH];
    logic [DATA_W-1:0] m_rd1, m_rd2;
    logic              m_busy1, m_busy2;

    regfile_sb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RS1       (RS1),
        .RS2       (RS2),
        .RdEn      (RdEn),
        .RD        (RD),
        .WData     (WData),
        .RegWr     (RegWr),
        .AllocEn   (AllocEn),
        .AllocAddr (AllocAddr),
        .RD1       (RD1),
        .RD2       (RD2),
        .Busy1     (Busy1),
        .Busy2     (Busy2)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model of one rising edge: state first, then reads see the post-write value.
    task automatic model_edge();
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_rd1 = '0; m_rd2 = '0; m_busy1 = 1'b0; m_busy2 = 1'b0;
        end else begin
            if (RegWr && RD != 0) begin
                m_regs[RD] = WData;
                m_busy[RD] = 1'b0;
            end
            if (AllocEn && AllocAddr != 0) m_busy[AllocAddr] = 1'b1;
            if (RdEn) begin
                m_rd1   = m_regs[RS1];
                m_rd2   = m_regs[RS2];
                m_busy1 = m_busy[RS1];
                m_busy2 = m_busy[RS2];
            end
        end
    endtask

    // Apply one cycle of inputs, advance, then compare all outputs to the model.
    task automatic cycle(input logic rst, input logic rden,
                         input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                         input logic regwr, input logic [ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] wdata,
                         input logic allocen, input logic [ADDR_W-1:0] allocaddr);
        Reset = rst; RdEn = rden; RS1 = rs1; RS2 = rs2;
        RegWr = regwr; RD = rd; WData = wdata;
        AllocEn = allocen; AllocAddr = allocaddr;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check("rd1",   64'(RD1),   64'(m_rd1));
        check("rd2",   64'(RD2),   64'(m_rd2));
        check("busy1", 64'(Busy1), 64'(m_busy1));
        check("busy2", 64'(Busy2), 64'(m_busy2));
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 5));
        return ADDR_W'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_rd1 = '0; m_rd2 = '0; m_busy1 = 1'b0; m_busy2 = 1'b0;

        // Reset for two cycles, then read 5 and 31
        cycle(1, 1, 5'd5, 5'd31, 1, 5'd5, 32'hFFFF_0000, 1, 5'd31);
        cycle(1, 1, 5'd5, 5'd31, 0, 5'd0, 32'h0, 0, 5'd0);
        cycle(0, 1, 5'd5, 5'd31, 0, 5'd0, 32'h0, 0, 5'd0);
        check("reset_rd1", 64'(RD1), 64'h0);
        check("reset_rd2", 64'(RD2), 64'h0);
        check("reset_busy", 64'({Busy1, Busy2}), 64'h0);

        // Write then read back through storage
        cycle(0, 0, 5'd0, 5'd0, 1, 5'd7, 32'hDEAD_BEEF, 0, 5'd0);
        cycle(0, 1, 5'd7, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0);
        check("readback_rd1", 64'(RD1), 64'hDEAD_BEEF);

        // Same-cycle write bypass to both ports
        cycle(0, 1, 5'd3, 5'd3, 1, 5'd3, 32'h1234_5678, 0, 5'd0);
        check("bypass_rd1", 64'(RD1), 64'h1234_5678);
        check("bypass_rd2", 64'(RD2), 64'h1234_5678);

        // Register 0 ignores writes and allocates
        cycle(0, 0, 5'd0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0);
        cycle(0, 1, 5'd0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0);
        check("zero_rd1", 64'(RD1), 64'h0);
        check("zero_busy1", 64'(Busy1), 64'h0);

        // RdEn low holds outputs while writes still land
        cycle(0, 0, 5'd7, 5'd3, 1, 5'd7, 32'hCAFE_F00D, 1, 5'd3);
        check("hold_rd1", 64'(RD1), 64'h0);
        cycle(0, 1, 5'd7, 5'd3, 0, 5'd0, 32'h0, 0, 5'd0);
        check("hold_then_rd1", 64'(RD1), 64'hCAFE_F00D);
        check("hold_then_busy2", 64'(Busy2), 64'h1);

        // Scoreboard sequence on register 9
        cycle(0, 0, 5'd0, 5'd9, 0, 5'd0, 32'h0, 1, 5'd9);
        cycle(0, 1, 5'd0, 5'd9, 0, 5'd0, 32'h0, 0, 5'd0);
        check("sb_alloc_busy2", 64'(Busy2), 64'h1);
        cycle(0, 1, 5'd0, 5'd9, 1, 5'd9, 32'h0BAD_0009, 1, 5'd9);
        check("sb_wr_alloc_busy2", 64'(Busy2), 64'h1);
        check("sb_wr_alloc_rd2", 64'(RD2), 64'h0BAD_0009);
        cycle(0, 1, 5'd0, 5'd9, 1, 5'd9, 32'h0600_D009, 0, 5'd0);
        check("sb_clear_busy2", 64'(Busy2), 64'h0);
        check("sb_clear_rd2", 64'(RD2), 64'h0600_D009);

        // Reset mid-operation discards the write and allocate
        cycle(0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 1, 5'd4);
        cycle(1, 1, 5'd4, 5'd4, 1, 5'd4, 32'hA5A5_A5A5, 1, 5'd4);
        cycle(0, 1, 5'd4, 5'd9, 0, 5'd0, 32'h0, 0, 5'd0);
        check("midrst_rd1", 64'(RD1), 64'h0);
        check("midrst_busy1", 64'(Busy1), 64'h0);
        check("midrst_rd2", 64'(RD2), 64'h0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  rnd_addr(), rnd_addr(),
                  ($urandom_range(0, 1) == 1), rnd_addr(), DATA_W'($urandom()),
                  ($urandom_range(0, 2) == 0), rnd_addr());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a built-in busy-bit scoreboard for the pipelined datapath. Provides two registered read ports, one write port and one allocate port. Read data is bypassed from a same-cycle write. Register 0 is hardwired to zero, and every register and busy bit clears on reset. It replaces the fixed 32×32 register file in the decode stage and reports per-operand hazard status to the hazard unit.

## Interface
Parameters:
- DATA_W, default 32, register width in bits.
- ADDR_W, default 5, address width; depth = 2**ADDR_W registers, index 0 hardwired zero.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- RS1  in  ADDR_W  read port 1 address.
- RS2  in  ADDR_W  read port 2 address.
- RdEn  in  1  read enable; when 0, RD1/RD2/Busy1/Busy2 hold their values.
- RD  in  ADDR_W  write address.
- WData  in  DATA_W  write data.
- RegWr  in  1  write enable.
- AllocEn  in  1  mark AllocAddr busy (an in-flight producer has been issued).
- AllocAddr  in  ADDR_W  register to mark busy.
- RD1  out  DATA_W  registered read data, port 1.
- RD2  out  DATA_W  registered read data, port 2.
- Busy1  out  1  registered busy status of RS1.
- Busy2  out  1  registered busy status of RS2.

## Operation
- Storage: registers 1..2**ADDR_W-1 of DATA_W bits, plus one busy bit per register.
- Register 0 always reads 0 and is never busy. Writes and allocates to address 0 are ignored.
- Write: if RegWr and RD≠0, regs[RD] ← WData and busy[RD] ← 0 at the edge.
- Allocate: if AllocEn and AllocAddr≠0, busy[AllocAddr] ← 1 at the edge.
- Same-address write and allocate in one cycle: the data is written and busy stays 1, because the allocate belongs to the newer producer.
- Read, with RdEn=1 at the edge:
  - RDn ← (RegWr && RD==RSn && RSn≠0) ? WData : regs[RSn], so a write bypasses to a same-cycle read.
  - Busyn reflects the post-edge busy state of RSn. It therefore includes a same-cycle allocate (→1) and a same-cycle write-clear (→0), with allocate winning if both target RSn.
- RS1==RS2 is legal; both ports return identical values.
- RdEn=0 does not block writes or allocates.

## Timing
- Read latency: 1 cycle. Address at edge k gives data valid after edge k, usable in cycle k+1.
- Write-to-read through storage: a write at edge k is visible to any read sampled at edge k or later, via the bypass at k and storage thereafter.
- Reset (Reset=1 at edge):
  - all registers ← 0, all busy ← 0, RD1=RD2=0, Busy1=Busy2=0;
  - concurrent RegWr/AllocEn/RdEn are ignored;
  - reset asserted mid-stream discards pending operations with no partial writes;
  - first valid operation is at the first edge with Reset=0.
- No combinational path from inputs to outputs.

## Structure
- Package regfile_pkg:
  - default DATA_W/ADDR_W constants;
  - ZERO_REG localparam (0);
  - a function returning the bypass-select condition.
- Sub-module regfile_scoreboard:
  - holds the busy vector and the allocate/clear/priority logic;
  - outputs the next-state busy bit per read address.
- Top module holds the data array and the read/bypass registers.
- Target size is roughly 150–250 lines of RTL in total.

## Test plan
- Reset then read: Reset=1 for 2 cycles; RS1=5, RS2=31 → RD1=RD2=0, Busy1=Busy2=0.
- Write/readback: write regs[7]=32'hDEADBEEF; next cycle RS1=7 → RD1=32'hDEADBEEF one cycle later.
- Bypass: RegWr=1, RD=3, WData=32'h12345678, RS1=RS2=3 in the same cycle → RD1=RD2=32'h12345678 next cycle.
- Zero register: write 32'hFFFFFFFF to RD=0 and AllocEn with AllocAddr=0 → reading RS1=0 gives RD1=0, Busy1=0.
- Scoreboard sequence on register 9:
  - AllocEn, AllocAddr=9 → next read of RS2=9 shows Busy2=1;
  - RegWr RD=9 with AllocEn AllocAddr=9 in the same cycle → Busy2 stays 1;
  - a later plain write to 9 → Busy2=0 and RD2 equals the written data.
- Reset mid-operation: RegWr=1, RD=4, WData=32'hA5A5A5A5, AllocEn=1, AllocAddr=4, all with Reset=1 → afterwards RS1=4 gives RD1=0, Busy1=0.
